// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: op encodings, rounding modes, flag positions,
// and per-op latency lookup.
package fpu_pkg;

    localparam logic [6:0] FADD_S   = 7'b0000000;
    localparam logic [6:0] FSUB_S   = 7'b0000100;
    localparam logic [6:0] FMUL_S   = 7'b0001000;
    localparam logic [6:0] FMADD_S  = 7'b1000011;
    localparam logic [6:0] FMSUB_S  = 7'b1000111;
    localparam logic [6:0] FNMSUB_S = 7'b1001011;
    localparam logic [6:0] FNMADD_S = 7'b1001111;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Latency field width; a latency of 0 marks an unsupported op.
    localparam int LAT_W = 3;

    function automatic logic [LAT_W-1:0] op_latency(input logic [6:0] funct7);
        logic [LAT_W-1:0] lat;
        case (funct7)
            FADD_S, FSUB_S:                         lat = LAT_W'(4);
            FMUL_S:                                 lat = LAT_W'(5);
            FMADD_S, FMSUB_S, FNMADD_S, FNMSUB_S:   lat = LAT_W'(6);
            default:                                lat = '0;
        endcase
        return lat;
    endfunction

    function automatic logic is_fma(input logic [6:0] funct7);
        return (funct7 == FMADD_S) || (funct7 == FMSUB_S) ||
               (funct7 == FNMADD_S) || (funct7 == FNMSUB_S);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_slot_queue.sv
// Completion slot queue: one entry per future cycle. Entry 1 is the head
// (the op whose result is due this cycle); everything shifts down each clock.
module fpu_slot_queue
    import fpu_pkg::*;
#(
    parameter int MAX_LAT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_en,
    input  logic [LAT_W-1:0] ins_lat,
    input  logic [4:0]       ins_rd,
    input  logic             kill_all,
    output logic             head_valid,
    output logic             head_kill,
    output logic [4:0]       head_rd,
    output logic [MAX_LAT:0] occ_next
);

    // One spare always-empty entry above the top keeps the shift uniform.
    logic [MAX_LAT+1:1] valid_q;
    logic [MAX_LAT+1:1] kill_q;
    logic [4:0]         rd_q [1:MAX_LAT+1];

    // Shift toward the head, mark everything killed on flush, insert at L.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            kill_q  <= '0;
            for (int i = 1; i <= MAX_LAT + 1; i++) rd_q[i] <= '0;
        end else begin
            for (int i = 1; i <= MAX_LAT; i++) begin
                if (ins_en && (ins_lat == LAT_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    kill_q[i]  <= 1'b0;
                    rd_q[i]    <= ins_rd;
                end else begin
                    valid_q[i] <= valid_q[i+1];
                    kill_q[i]  <= kill_q[i+1] | kill_all;
                    rd_q[i]    <= rd_q[i+1];
                end
            end
            valid_q[MAX_LAT+1] <= 1'b0;
            kill_q[MAX_LAT+1]  <= 1'b0;
            rd_q[MAX_LAT+1]    <= '0;
        end
    end

    assign head_valid = valid_q[1];
    assign head_kill  = kill_q[1];
    assign head_rd    = rd_q[1];
    // Bit i: slot i would be occupied after this cycle's shift. Bit 0 unused.
    assign occ_next   = {valid_q[MAX_LAT+1:2], 1'b0};

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: hazard/slot checks, single-pulse issue to the FPU,
// fixed-latency completion tracking, writeback and sticky fflags.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int MAX_LAT = 6,
    parameter int NREG    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_funct7,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rs3,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_rs3_data,
    input  logic [2:0]  csr_frm,
    input  logic        flush,
    output logic        fpu_op,
    output logic [31:0] fpu_rs1_data,
    output logic [31:0] fpu_rs2_data,
    output logic [31:0] fpu_rs3_data,
    output logic [6:0]  fpu_funct7,
    output logic [2:0]  fpu_funct3,
    output logic [2:0]  fpu_frm,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    input  logic        fpu_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  fflags_acc,
    input  logic        fflags_clr,
    output logic        illegal_op,
    output logic        protocol_err
);

    localparam int IGN_W = $clog2(MAX_LAT + 1);

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic             clr_pend;
    logic [4:0]       clr_rd;
    logic [IGN_W-1:0] ign_cnt;

    logic [LAT_W-1:0] lat;
    logic [2:0]       rm;
    logic             fma;
    logic             legal;
    logic             hazard;
    logic             slot_hit;
    logic             issue;

    logic             head_valid;
    logic             head_kill;
    logic [4:0]       head_rd;
    logic [MAX_LAT:0] occ_next;
    logic             live_head;
    logic             done_ok;
    logic             perr_evt;

    fpu_slot_queue #(.MAX_LAT(MAX_LAT)) u_slot_queue (
        .clk        (clk),
        .rst        (rst),
        .ins_en     (issue),
        .ins_lat    (lat),
        .ins_rd     (in_rd),
        .kill_all   (flush),
        .head_valid (head_valid),
        .head_kill  (head_kill),
        .head_rd    (head_rd),
        .occ_next   (occ_next)
    );

    // Decode, hazard and slot checks, and the accept/issue decision.
    always_comb begin
        lat      = op_latency(in_funct7);
        fma      = is_fma(in_funct7);
        rm       = (in_funct3 == DYN) ? csr_frm : in_funct3;
        legal    = (lat != '0) && (rm <= RMM);
        hazard   = busy[in_rs1] | busy[in_rs2] | busy[in_rd] | (fma & busy[in_rs3]);
        slot_hit = occ_next[lat];
        // Illegal ops are consumed regardless of hazards; they never enter the pipe.
        in_ready = ~rst & ~flush & (~legal | (~hazard & ~slot_hit));
        issue    = in_valid & in_ready & legal;
    end

    assign fpu_op       = issue;
    assign fpu_rs1_data = issue ? in_rs1_data : '0;
    assign fpu_rs2_data = issue ? in_rs2_data : '0;
    assign fpu_rs3_data = issue ? in_rs3_data : '0;
    assign fpu_funct7   = issue ? in_funct7   : '0;
    assign fpu_funct3   = issue ? rm          : '0;
    assign fpu_frm      = fpu_funct3;

    // Head-of-queue completion; a flush this cycle kills the head as well.
    always_comb begin
        live_head = head_valid & ~head_kill & ~flush;
        done_ok   = live_head & fpu_ready;
        perr_evt  = (live_head & ~fpu_ready) |
                    (~head_valid & fpu_ready & (ign_cnt == '0));
    end

    // Busy scoreboard next value: clears lag writeback by one cycle.
    always_comb begin
        busy_nxt = busy;
        if (clr_pend) busy_nxt[clr_rd] = 1'b0;
        if (issue)    busy_nxt[in_rd]  = 1'b1;
        if (flush)    busy_nxt         = '0;
    end

    // Scoreboard, writeback, flag accumulation and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            clr_pend     <= 1'b0;
            clr_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            fflags_acc   <= '0;
            illegal_op   <= 1'b0;
            protocol_err <= 1'b0;
            ign_cnt      <= IGN_W'(MAX_LAT);
        end else begin
            busy       <= busy_nxt;
            illegal_op <= in_valid & in_ready & ~legal;
            wb_valid   <= done_ok;
            if (done_ok) begin
                wb_rd   <= head_rd;
                wb_data <= fpu_result;
            end
            fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | (done_ok ? fpu_flags : 5'b0);
            // A missing result still frees its destination register.
            clr_pend <= live_head;
            clr_rd   <= head_rd;
            if (perr_evt) protocol_err <= 1'b1;
            if (ign_cnt != '0) ign_cnt <= ign_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a scheduled-result FPU stub.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2, in_rs3;
    logic [31:0] in_rs1_data, in_rs2_data, in_rs3_data;
    logic [2:0]  csr_frm;
    logic        flush;
    logic        fpu_op;
    logic [31:0] fpu_rs1_data, fpu_rs2_data, fpu_rs3_data;
    logic [6:0]  fpu_funct7;
    logic [2:0]  fpu_funct3, fpu_frm;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        fpu_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  fflags_acc;
    logic        fflags_clr;
    logic        illegal_op;
    logic        protocol_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t;

    int          sc_cyc [16];
    logic [31:0] sc_res [16];
    logic [4:0]  sc_flg [16];
    int          n_sched = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.MAX_LAT(6), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct7(in_funct7), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
        .csr_frm(csr_frm), .flush(flush),
        .fpu_op(fpu_op),
        .fpu_rs1_data(fpu_rs1_data), .fpu_rs2_data(fpu_rs2_data), .fpu_rs3_data(fpu_rs3_data),
        .fpu_funct7(fpu_funct7), .fpu_funct3(fpu_funct3), .fpu_frm(fpu_frm),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
        .illegal_op(illegal_op), .protocol_err(protocol_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sched(input int due, input logic [31:0] res, input logic [4:0] flg);
        sc_cyc[n_sched] = due;
        sc_res[n_sched] = res;
        sc_flg[n_sched] = flg;
        n_sched++;
    endtask

    // Advance one cycle; the FPU stub presents any result due this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        fpu_ready  = 1'b0;
        fpu_result = '0;
        fpu_flags  = '0;
        for (int i = 0; i < n_sched; i++) begin
            if (sc_cyc[i] == cyc) begin
                fpu_ready  = 1'b1;
                fpu_result = sc_res[i];
                fpu_flags  = sc_flg[i];
            end
        end
    endtask

    task automatic offer(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rs3, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3);
        in_valid    = 1'b1;
        in_funct7   = f7;
        in_funct3   = f3;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rs3      = rs3;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_rs3_data = d3;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_funct7 = '0; in_funct3 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_rs3_data = '0;
        csr_frm = '0; flush = 1'b0; fflags_clr = 1'b0;
        fpu_result = '0; fpu_flags = '0; fpu_ready = 1'b0;

        tick(); tick(); #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_fpu_op", fpu_op, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_fflags", fflags_acc, 0);
        check_eq("rst_perr", protocol_err, 0);
        rst = 1'b0;
        tick(); #1;
        check_eq("idle_in_ready", in_ready, 1);

        // FADD.S 1.5 + 2.5, latency 4
        tick(); t = cyc;
        offer(FADD_S, RNE, 3, 1, 2, 0, 32'h3FC00000, 32'h40200000, 0); #1;
        check_eq("fadd_ready", in_ready, 1);
        check_eq("fadd_op", fpu_op, 1);
        check_eq("fadd_rs1", fpu_rs1_data, 32'h3FC00000);
        check_eq("fadd_rs2", fpu_rs2_data, 32'h40200000);
        check_eq("fadd_f7", fpu_funct7, FADD_S);
        sched(t + 4, 32'h40800000, 5'b0);
        tick(); in_valid = 1'b0; #1;
        check_eq("fadd_op_once", fpu_op, 0);
        tick(); tick(); tick(); #1;
        check_eq("fadd_wb_early", wb_valid, 0);
        tick(); #1;
        check_eq("fadd_wb_valid", wb_valid, 1);
        check_eq("fadd_wb_rd", wb_rd, 3);
        check_eq("fadd_wb_data", wb_data, 32'h40800000);
        check_eq("fadd_fflags", fflags_acc, 0);
        tick(); #1;
        check_eq("fadd_wb_once", wb_valid, 0);

        // FMADD 2*3+4 then FADD colliding on the writeback slot
        tick(); t = cyc;
        offer(FMADD_S, RNE, 1, 10, 11, 12, 32'h40000000, 32'h40400000, 32'h40800000); #1;
        check_eq("fma_op", fpu_op, 1);
        check_eq("fma_rs3", fpu_rs3_data, 32'h40800000);
        check_eq("fma_f7", fpu_funct7, FMADD_S);
        sched(t + 6, 32'h41200000, 5'b00001);
        tick(); in_valid = 1'b0;
        tick();
        offer(FADD_S, RNE, 2, 13, 14, 0, 32'h3F800000, 32'h40000000, 0); #1;
        check_eq("slot_stall_ready", in_ready, 0);
        check_eq("slot_stall_op", fpu_op, 0);
        tick(); #1;
        check_eq("slot_free_ready", in_ready, 1);
        check_eq("slot_free_op", fpu_op, 1);
        sched(t + 7, 32'h40400000, 5'b00100);
        tick(); in_valid = 1'b0;
        tick(); tick(); tick(); #1;
        check_eq("fma_wb_valid", wb_valid, 1);
        check_eq("fma_wb_rd", wb_rd, 1);
        check_eq("fma_wb_data", wb_data, 32'h41200000);
        check_eq("fma_fflags", fflags_acc, 5'b00001);
        fflags_clr = 1'b1;
        tick(); fflags_clr = 1'b0; #1;
        check_eq("fadd2_wb_valid", wb_valid, 1);
        check_eq("fadd2_wb_rd", wb_rd, 2);
        check_eq("fadd2_wb_data", wb_data, 32'h40400000);
        check_eq("clr_then_acc", fflags_acc, 5'b00100);
        tick();

        // FMUL rd=5 then RAW-dependent FSUB with dynamic rounding
        tick(); t = cyc;
        offer(FMUL_S, RNE, 5, 1, 2, 0, 32'h40000000, 32'h40400000, 0); #1;
        check_eq("fmul_op", fpu_op, 1);
        sched(t + 5, 32'h40C00000, 5'b0);
        csr_frm = RUP;
        for (int k = 1; k <= 6; k++) begin
            tick();
            offer(FSUB_S, DYN, 6, 5, 2, 0, 32'h40C00000, 32'h40000000, 0); #1;
            check_eq($sformatf("raw_stall_%0d", k), in_ready, 0);
        end
        check_eq("fmul_wb_valid", wb_valid, 1);
        check_eq("fmul_wb_rd", wb_rd, 5);
        tick(); #1;
        check_eq("raw_issue_ready", in_ready, 1);
        check_eq("raw_issue_op", fpu_op, 1);
        check_eq("dyn_funct3", fpu_funct3, RUP);
        check_eq("dyn_frm", fpu_frm, RUP);
        sched(t + 11, 32'h40800000, 5'b0);
        tick(); in_valid = 1'b0; csr_frm = RNE;
        repeat (5) tick();

        // Illegal dynamic rounding mode, then the same op with a legal mode
        tick();
        csr_frm = 3'b101;
        offer(FADD_S, DYN, 3, 1, 2, 0, 32'h3F800000, 32'h3F800000, 0); #1;
        check_eq("ill_in_ready", in_ready, 1);
        check_eq("ill_fpu_op", fpu_op, 0);
        tick(); in_valid = 1'b0; #1;
        check_eq("ill_pulse", illegal_op, 1);
        tick(); #1;
        check_eq("ill_pulse_end", illegal_op, 0);
        csr_frm = RNE;
        offer(FADD_S, DYN, 3, 1, 2, 0, 32'h3F800000, 32'h3F800000, 0); #1;
        check_eq("dyn0_ready", in_ready, 1);
        check_eq("dyn0_op", fpu_op, 1);
        check_eq("dyn0_funct3", fpu_funct3, RNE);
        sched(cyc + 4, 32'h40000000, 5'b0);
        tick(); in_valid = 1'b0;
        repeat (6) tick();

        // Flush kills an in-flight FMUL and frees its destination
        tick(); t = cyc;
        offer(FMUL_S, RNE, 7, 1, 2, 0, 32'h40000000, 32'h40000000, 0); #1;
        check_eq("fl_fmul_op", fpu_op, 1);
        sched(t + 5, 32'h41000000, 5'b00010);
        tick(); in_valid = 1'b0;
        tick(); flush = 1'b1;
        offer(FADD_S, RNE, 8, 1, 2, 0, 0, 0, 0); #1;
        check_eq("flush_in_ready", in_ready, 0);
        check_eq("flush_fpu_op", fpu_op, 0);
        tick(); flush = 1'b0;
        offer(FADD_S, RNE, 9, 7, 7, 0, 32'h3F800000, 32'h3F800000, 0); #1;
        check_eq("post_flush_ready", in_ready, 1);
        check_eq("post_flush_op", fpu_op, 1);
        sched(t + 7, 32'h40000000, 5'b0);
        tick(); in_valid = 1'b0;
        tick(); tick(); #1;
        check_eq("killed_no_wb", wb_valid, 0);
        check_eq("killed_no_perr", protocol_err, 0);
        check_eq("killed_no_flags", fflags_acc, 5'b00100);
        tick(); tick(); #1;
        check_eq("post_flush_wb", wb_valid, 1);
        check_eq("post_flush_wb_rd", wb_rd, 9);
        tick(); tick();

        // FPU withholds its result: sticky protocol error, busy freed
        tick(); t = cyc;
        offer(FADD_S, RNE, 4, 1, 2, 0, 32'h3F800000, 32'h3F800000, 0); #1;
        check_eq("wh_op", fpu_op, 1);
        tick(); in_valid = 1'b0; in_rd = 10; in_rs1 = 4; in_rs2 = 2; #1;
        check_eq("wh_busy", in_ready, 0);
        tick(); tick(); tick(); #1;
        check_eq("wh_perr_before", protocol_err, 0);
        tick(); #1;
        check_eq("wh_perr", protocol_err, 1);
        check_eq("wh_no_wb", wb_valid, 0);
        tick(); #1;
        check_eq("wh_busy_freed", in_ready, 1);
        tick(); #1;
        check_eq("wh_perr_sticky", protocol_err, 1);

        // Reset mid-run clears everything
        rst = 1'b1;
        tick(); #1;
        check_eq("r2_in_ready", in_ready, 0);
        check_eq("r2_fpu_op", fpu_op, 0);
        check_eq("r2_wb_valid", wb_valid, 0);
        check_eq("r2_wb_rd", wb_rd, 0);
        check_eq("r2_wb_data", wb_data, 0);
        check_eq("r2_fflags", fflags_acc, 0);
        check_eq("r2_perr", protocol_err, 0);
        check_eq("r2_illegal", illegal_op, 0);
        check_eq("r2_funct3", fpu_funct3, 0);
        rst = 1'b0;
        sched(cyc + 2, 32'hDEADBEEF, 5'b11111);
        tick(); tick(); tick(); #1;
        check_eq("stale_ready_ignored", protocol_err, 0);
        check_eq("stale_no_wb", wb_valid, 0);
        repeat (8) tick();
        sched(cyc + 1, 32'h0, 5'b0);
        tick(); tick(); #1;
        check_eq("stray_ready_perr", protocol_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
